ireg_wb: RTL
============

Name: ireg_wb

Overview:
- Write-side controller for the integer register file. It drives the register file's rd / rdx_v / rdm_v / rd_data_x write port.
- It merges two result sources:
  - single-cycle execute results;
  - long-latency results (load / divide), which carry a ready/valid handshake.
- It keeps a per-register pending scoreboard for long-latency destinations and stalls decode on RAW and WAW hazards against them.
- Sits between execute / long-latency units and the register file, beside decode.

Parameters:
LONG_MAX, 4, maximum outstanding long-latency ops (1..15)
CNT_W, 4, width of the outstanding counter; must hold LONG_MAX

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
id_valid  in  1  decode presents an instruction this cycle
id_rs1  in  5  decode source 1
id_rs2  in  5  decode source 2
id_rd  in  5  decode destination
id_rd_v  in  1  instruction writes id_rd
id_long  in  1  instruction's result returns on the long-latency path
id_stall  out  1  hold decode; the instruction is not issued
ex_valid  in  1  execute result valid (no backpressure possible)
ex_rd  in  5  execute destination
ex_data  in  32  execute result
lu_valid  in  1  long-latency result valid
lu_rd  in  5  long-latency destination
lu_data  in  32  long-latency result
lu_ready  out  1  long-latency result accepted this cycle
rd  out  5  register file write index
rdx_v  out  1  write valid, bypassable from execute
rdm_v  out  1  write commit valid
rd_data_x  out  32  register file write data
pending  out  32  scoreboard, bit n = long-latency write to xn outstanding

Behaviour:
- Reset (async, active-high) state:
  - pending = 0.
  - Outstanding counter = 0.
  - id_stall = 0.
  - Outputs are combinational from state and inputs, so with no valid inputs: rdx_v = rdm_v = 0, rd = 0, rd_data_x = 0.
- Write arbitration (combinational, same cycle):
  - ex_valid has absolute priority.
  - lu_ready = ~ex_valid.
  - Selected source drives rd / rd_data_x.
  - With no source selected, rd = 0 and rd_data_x = 0.
- rdx_v and rdm_v:
  - Both equal (selected valid) & (selected rd != 0).
  - Writes to x0 are suppressed, but x0 completions still count as accepted.
- Long-latency handshake:
  - lu_valid must hold lu_rd / lu_data stable until lu_ready.
  - Completion = lu_valid & lu_ready.
- Hazard check (combinational), with clr = completion ? (1 << lu_rd) : 0 and eff = pending & ~clr:
  - RAW: eff[id_rs1] or eff[id_rs2] set.
  - WAW: id_rd_v & eff[id_rd].
  - Full: id_long & id_rd_v & (count == LONG_MAX) & ~completion.
  - id_stall = id_valid & (RAW | WAW | Full).
  - A completion in the same cycle releases the stall: the register file bypass covers the same-cycle write.
- Register index 0 is never pending.
- Issue = id_valid & ~id_stall & id_rd_v & id_long & (id_rd != 0).
  - Issue sets pending[id_rd] at the next edge.
  - Issue with id_rd = 0 does not touch pending or the counter.
- Completion clears pending[lu_rd] at the next edge.
  - Same-index set and clear cannot coincide, because WAW blocks the issue.
- Counter:
  - Increments on issue, decrements on completion, unchanged when both occur.
  - Never exceeds LONG_MAX, never underflows.
- Completion with pending[lu_rd] = 0 (protocol error): write still performed, pending unchanged, counter saturates at 0.
- Reset mid-operation: all outstanding state cleared; late lu results after reset are written but do not corrupt the counter.

Optional Feature:
IREG_WB_PERF_EN
- Defined: adds outputs stall_raw_cnt [31:0] and lu_wait_cnt [31:0], both reset to 0 and wrapping at 2^32.
  - stall_raw_cnt increments each cycle id_stall is high due to RAW.
  - lu_wait_cnt increments each cycle lu_valid & ~lu_ready.
- Undefined: neither port nor the counters exist; all other behaviour is identical.

Test Plan:
1. Reset, then ex_valid=1, ex_rd=5, ex_data=0x12345678 -> same cycle rd=5, rdx_v=rdm_v=1, rd_data_x=0x12345678; ex_rd=0 -> rdx_v=rdm_v=0.
2. Issue long op to x7, then decode id_rs1=7 -> id_stall=1 until a cycle with lu_valid=1, lu_rd=7; that cycle id_stall=0 and pending[7] clears at the next edge.
3. ex_valid=1 and lu_valid=1 (lu_rd=3, lu_data=0xA5A5A5A5) together -> lu_ready=0, ex written; next cycle with ex_valid=0 -> lu_ready=1, rd=3, data 0xA5A5A5A5.
4. Issue LONG_MAX=4 long ops to x1..x4, then a 5th long op to x9 -> id_stall=1; completion of x2 in that cycle -> id_stall=0, counter stays 4.
5. Long op pending on x8, decode writes x8 (id_rd_v=1, no source match) -> id_stall=1 (WAW); assert reset mid-stall -> pending=0, id_stall=0 immediately.
6. With IREG_WB_PERF_EN: 3 RAW stall cycles and 2 blocked lu cycles -> stall_raw_cnt=3, lu_wait_cnt=2.

Source files
------------

// File: rtl/ireg_wb.sv
// ireg_wb - write-side controller for the integer register file.
//
// Purpose:
//   Merges single-cycle execute results and long-latency (load/divide)
//   results onto the register file write port. Execute always wins the
//   port. Long-latency results wait on a ready/valid handshake.
//   Keeps a per-register pending scoreboard for long-latency destinations.
//   Stalls decode on RAW/WAW hazards against pending registers, and when the
//   outstanding limit is reached.
//
// Ports:
//   clk, reset                 clock (rising edge), async active-high reset
//   id_valid/id_rs1/id_rs2     decode instruction and its sources
//   id_rd/id_rd_v/id_long      decode destination, write enable, long-latency flag
//   id_stall                   hold decode, instruction not issued
//   ex_valid/ex_rd/ex_data     execute result (no backpressure)
//   lu_valid/lu_rd/lu_data     long-latency result
//   lu_ready                   long-latency result accepted this cycle
//   rd/rdx_v/rdm_v/rd_data_x   register file write port
//   pending                    scoreboard, bit n = long write to xn outstanding
//
// Optional feature (macro IREG_WB_PERF_EN):
//   Adds the stall_raw_cnt and lu_wait_cnt 32-bit wrapping performance counters.
//   stall_raw_cnt counts cycles in which decode stalls on a RAW hazard.
//   lu_wait_cnt counts cycles in which a long-latency result is blocked.

module ireg_wb #(
    parameter int LONG_MAX = 4,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_rd_v,
    input  logic        id_long,
    output logic        id_stall,
    input  logic        ex_valid,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_data,
    input  logic        lu_valid,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    output logic [4:0]  rd,
    output logic        rdx_v,
    output logic        rdm_v,
    output logic [31:0] rd_data_x,
    output logic [31:0] pending
`ifdef IREG_WB_PERF_EN
    ,
    output logic [31:0] stall_raw_cnt,
    output logic [31:0] lu_wait_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LONG_MAX);

    logic [31:0]      pending_q, pending_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             completion;
    logic             sel_v;
    logic [31:0]      clr_vec;
    logic [31:0]      set_vec;
    logic [31:0]      eff;
    logic             raw_hit;
    logic             waw_hit;
    logic             full_hit;
    logic             issue;
    logic             cnt_inc;
    logic             cnt_dec;

    // Write port arbitration: execute has absolute priority.
    // A completion frees its scoreboard bit in the same cycle, which lets a
    // dependent instruction in decode go ahead. The register file bypass
    // supplies the value that is being written this cycle.
    always_comb begin
        lu_ready   = ~ex_valid;
        completion = lu_valid & ~ex_valid;
        sel_v      = 1'b0;
        rd         = 5'd0;
        rd_data_x  = 32'd0;
        if (ex_valid) begin
            sel_v     = 1'b1;
            rd        = ex_rd;
            rd_data_x = ex_data;
        end else if (lu_valid) begin
            sel_v     = 1'b1;
            rd        = lu_rd;
            rd_data_x = lu_data;
        end
        // x0 completions are still accepted, but they never reach the array.
        rdx_v = sel_v & (rd != 5'd0);
        rdm_v = sel_v & (rd != 5'd0);

        clr_vec = 32'd0;
        if (completion) begin
            clr_vec[lu_rd] = 1'b1;
        end
        eff = pending_q & ~clr_vec;

        raw_hit  = eff[id_rs1] | eff[id_rs2];
        waw_hit  = id_rd_v & eff[id_rd];
        full_hit = id_long & id_rd_v & (count_q == CNT_MAX) & ~completion;
        id_stall = id_valid & (raw_hit | waw_hit | full_hit);

        issue = id_valid & ~id_stall & id_rd_v & id_long & (id_rd != 5'd0);
        set_vec = 32'd0;
        if (issue) begin
            set_vec[id_rd] = 1'b1;
        end
        pending_d    = eff | set_vec;
        pending_d[0] = 1'b0;
    end

    // Outstanding counter.
    // The counter decrements only for completions that retire a real
    // scoreboard entry. Stray completions, such as late results arriving
    // after a reset, therefore cannot push the counter below zero.
    // The counter also never exceeds LONG_MAX.
    always_comb begin
        cnt_dec = completion & pending_q[lu_rd] & (count_q != '0);
        cnt_inc = issue & ((count_q != CNT_MAX) | cnt_dec);
        count_d = count_q;
        if (cnt_inc && !cnt_dec) begin
            count_d = count_q + 1'b1;
        end else if (cnt_dec && !cnt_inc) begin
            count_d = count_q - 1'b1;
        end
    end

    // Scoreboard and counter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= 32'd0;
            count_q   <= '0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    assign pending = pending_q;

`ifdef IREG_WB_PERF_EN
    logic [31:0] stall_raw_cnt_q, stall_raw_cnt_d;
    logic [31:0] lu_wait_cnt_q, lu_wait_cnt_d;

    // Performance counters wrap naturally at 2^32.
    always_comb begin
        stall_raw_cnt_d = stall_raw_cnt_q;
        lu_wait_cnt_d   = lu_wait_cnt_q;
        if (id_valid && raw_hit) begin
            stall_raw_cnt_d = stall_raw_cnt_q + 32'd1;
        end
        if (lu_valid && !lu_ready) begin
            lu_wait_cnt_d = lu_wait_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_raw_cnt_q <= 32'd0;
            lu_wait_cnt_q   <= 32'd0;
        end else begin
            stall_raw_cnt_q <= stall_raw_cnt_d;
            lu_wait_cnt_q   <= lu_wait_cnt_d;
        end
    end

    assign stall_raw_cnt = stall_raw_cnt_q;
    assign lu_wait_cnt   = lu_wait_cnt_q;
`endif

endmodule
